// File: rtl/dff_response_checker_pkg.sv
// Shared lab definitions for the D flip-flop DUT and its response checker:
// checker state encoding and the reset > set > D priority rule.
package dff_response_checker_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    SYNC = 2'd1,
    RUN  = 2'd2,
    DONE = 2'd3
  } state_t;

  // Single definition of flip-flop priority so the DUT and checker cannot drift apart.
  function automatic logic dff_next(input logic ff_reset, input logic ff_set, input logic d);
    logic q;
    if (ff_reset)    q = 1'b0;
    else if (ff_set) q = 1'b1;
    else             q = d;
    return q;
  endfunction

endpackage

// File: rtl/dff_ref_model.sv
// One-bit reference flip-flop with reset > set > D priority; holds when en is low.
module dff_ref_model
  import dff_response_checker_pkg::*;
(
  input  logic CLK,
  input  logic Reset,
  input  logic en,
  input  logic ff_reset,
  input  logic ff_set,
  input  logic d,
  output logic q
);

  // NOTE: sequential state uses non-blocking assignments so every flop
  // samples pre-edge values regardless of block evaluation order.
  always_ff @(posedge CLK) begin
    if (Reset)   q <= 1'b0;
    else if (en) q <= dff_next(ff_reset, ff_set, d);
  end

endmodule

// File: rtl/dff_response_checker.sv
// Response checker for a single-bit D flip-flop DUT: runs a reference model
// beside the DUT, counts compared cycles and mismatches, reports pass/fail.
module dff_response_checker
  import dff_response_checker_pkg::*;
#(
  parameter int CNT_W     = 16,
  parameter int ERR_LIMIT = 8
) (
  input  logic             CLK,
  input  logic             Reset,
  input  logic             start,
  input  logic             stop,
  input  logic             dut_reset,
  input  logic             dut_set,
  input  logic             dut_d,
  input  logic             dut_q,
  output logic             busy,
  output logic             done,
  output logic             pass,
  output logic             fail,
  output logic             exp_q,
  output logic [CNT_W-1:0] chk_cnt,
  output logic [CNT_W-1:0] err_cnt,
  output logic [CNT_W-1:0] first_err_cyc
);

  localparam logic [CNT_W-1:0] CNT_MAX = '1;
  localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);
  localparam logic [CNT_W:0]   LIMIT   = (CNT_W + 1)'(ERR_LIMIT);

  state_t           state;
  state_t           state_nxt;
  logic             run;
  logic             mismatch;
  logic             limit_hit;
  logic             start_ok;
  logic [CNT_W-1:0] chk_inc;
  logic [CNT_W-1:0] err_inc;

  assign run      = (state == RUN);
  assign mismatch = run && (dut_q != exp_q);
  assign start_ok = start && ((state == IDLE) || (state == DONE));

  // Counters stick at all-ones instead of wrapping.
  assign chk_inc = (chk_cnt == CNT_MAX) ? chk_cnt : chk_cnt + CNT_ONE;
  assign err_inc = (err_cnt == CNT_MAX) ? err_cnt : err_cnt + CNT_ONE;

  // The limit-reaching mismatch is itself counted, so test the incremented value.
  assign limit_hit = (ERR_LIMIT != 0) && mismatch && ({1'b0, err_inc} >= LIMIT);

  dff_ref_model u_ref (
    .CLK      (CLK),
    .Reset    (Reset),
    .en       (busy),
    .ff_reset (dut_reset),
    .ff_set   (dut_set),
    .d        (dut_d),
    .q        (exp_q)
  );

  // NOTE: state_nxt gets a default before the case so no path leaves it
  // unassigned, which would otherwise infer a latch.
  always_comb begin
    state_nxt = state;
    unique case (state)
      IDLE: if (start) state_nxt = SYNC;
      SYNC: state_nxt = stop ? DONE : RUN;
      RUN:  if (stop || limit_hit) state_nxt = DONE;
      DONE: if (start) state_nxt = SYNC;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge CLK) begin
    if (Reset) state <= IDLE;
    else       state <= state_nxt;
  end

  always_ff @(posedge CLK) begin
    if (Reset || start_ok) begin
      chk_cnt       <= '0;
      err_cnt       <= '0;
      first_err_cyc <= '0;
    end else if (run) begin
      chk_cnt <= chk_inc;
      if (mismatch) begin
        err_cnt <= err_inc;
        if (err_cnt == '0) first_err_cyc <= chk_cnt;
      end
    end
  end

  assign busy = (state == SYNC) || (state == RUN);
  assign done = (state == DONE);
  assign pass = done && (err_cnt == '0);
  assign fail = (err_cnt != '0);

endmodule

// File: tb/tb_dff_response_checker.sv
// Scoreboard bench for dff_response_checker: a behavioural DFF acts as the DUT,
// expected model values are queued at stimulus time and popped after each edge.
module tb_dff_response_checker;

  typedef struct {
    logic q;
    int   chk;
    int   err;
    int   first;
  } sb_t;

  logic CLK = 1'b0;
  logic Reset, start, stop, dut_reset, dut_set, dut_d, dut_q;
  logic bq = 1'b0;
  logic inject, prio_bug;

  logic a_busy, a_done, a_pass, a_fail, a_exp_q;
  logic [15:0] a_chk, a_err, a_first;
  logic b_busy, b_done, b_pass, b_fail, b_exp_q;
  logic [3:0] b_chk, b_err, b_first;

  int   checks   = 0;
  int   failures = 0;
  int   cyc_no   = 0;
  logic model_q  = 1'b0;
  int   exp_chk, exp_err, exp_first;
  sb_t  sb[$];

  always #5 CLK = ~CLK;

  // Behavioural DUT; prio_bug swaps reset/set priority to provoke a mismatch.
  always @(posedge CLK)
    bq <= prio_bug ? (dut_set ? 1'b1 : (dut_reset ? 1'b0 : dut_d))
                   : (dut_reset ? 1'b0 : (dut_set ? 1'b1 : dut_d));
  assign dut_q = bq ^ inject;

  dff_response_checker #(.CNT_W(16), .ERR_LIMIT(8)) u_a (
    .CLK(CLK), .Reset(Reset), .start(start), .stop(stop),
    .dut_reset(dut_reset), .dut_set(dut_set), .dut_d(dut_d), .dut_q(dut_q),
    .busy(a_busy), .done(a_done), .pass(a_pass), .fail(a_fail), .exp_q(a_exp_q),
    .chk_cnt(a_chk), .err_cnt(a_err), .first_err_cyc(a_first)
  );

  dff_response_checker #(.CNT_W(4), .ERR_LIMIT(0)) u_b (
    .CLK(CLK), .Reset(Reset), .start(start), .stop(stop),
    .dut_reset(dut_reset), .dut_set(dut_set), .dut_d(dut_d), .dut_q(dut_q),
    .busy(b_busy), .done(b_done), .pass(b_pass), .fail(b_fail), .exp_q(b_exp_q),
    .chk_cnt(b_chk), .err_cnt(b_err), .first_err_cyc(b_first)
  );

  function automatic logic ref_next(input logic r, input logic s, input logic d);
    if (r) return 1'b0;
    if (s) return 1'b1;
    return d;
  endfunction

  task automatic tick();
    @(posedge CLK);
    @(negedge CLK);
    cyc_no++;
  endtask

  // One checker cycle: drive stimulus, queue expectations, pop and compare after the edge.
  task automatic cyc(input logic r, input logic s, input logic d,
                     input logic flip, input logic cmp, input logic stp);
    logic obs;
    sb_t  e;
    dut_reset = r;
    dut_set   = s;
    dut_d     = d;
    inject    = flip;
    stop      = stp;
    obs       = bq ^ flip;
    if (cmp) begin
      if (obs !== model_q) begin
        if (exp_err == 0) exp_first = exp_chk;
        exp_err++;
      end
      exp_chk++;
    end
    model_q = ref_next(r, s, d);
    sb.push_back('{model_q, exp_chk, exp_err, exp_first});
    tick();
    inject = 1'b0;
    stop   = 1'b0;
    e = sb.pop_front();
    checks++;
    if (a_exp_q !== e.q) begin
      failures++;
      $display("FAIL sb_exp_q cyc=%0d got=%b want=%b", cyc_no, a_exp_q, e.q);
    end
    checks++;
    if (int'(a_chk) !== e.chk) begin
      failures++;
      $display("FAIL sb_chk_cnt cyc=%0d got=%0d want=%0d", cyc_no, a_chk, e.chk);
    end
    checks++;
    if (int'(a_err) !== e.err) begin
      failures++;
      $display("FAIL sb_err_cnt cyc=%0d got=%0d want=%0d", cyc_no, a_err, e.err);
    end
    checks++;
    if (int'(a_first) !== e.first) begin
      failures++;
      $display("FAIL sb_first_err cyc=%0d got=%0d want=%0d", cyc_no, a_first, e.first);
    end
    checks++;
    if (a_fail !== (e.err != 0)) begin
      failures++;
      $display("FAIL sb_fail cyc=%0d got=%b want=%b", cyc_no, a_fail, (e.err != 0));
    end
  endtask

  task automatic start_run(input logic with_stop);
    start = 1'b1;
    stop  = with_stop;
    tick();
    start = 1'b0;
    stop  = 1'b0;
    exp_chk   = 0;
    exp_err   = 0;
    exp_first = 0;
    sb.delete();
    checks++;
    if ({a_busy, a_done, a_fail} !== 3'b100 || a_chk !== 16'd0 || a_err !== 16'd0 || a_first !== 16'd0) begin
      failures++;
      $display("FAIL start_state got busy=%b done=%b fail=%b chk=%0d err=%0d first=%0d want busy=1 done=0 fail=0 counters=0",
               a_busy, a_done, a_fail, a_chk, a_err, a_first);
    end
  endtask

  task automatic test_reset();
    Reset = 1'b1;
    tick();
    tick();
    checks++;
    if ({a_busy, a_done, a_pass, a_fail, a_exp_q} !== 5'b0 || a_chk !== 16'd0 || a_err !== 16'd0 || a_first !== 16'd0) begin
      failures++;
      $display("FAIL reset_a got busy=%b done=%b pass=%b fail=%b exp_q=%b chk=%0d err=%0d first=%0d want all 0",
               a_busy, a_done, a_pass, a_fail, a_exp_q, a_chk, a_err, a_first);
    end
    checks++;
    if ({b_busy, b_done, b_pass, b_fail, b_exp_q} !== 5'b0 || b_chk !== 4'd0 || b_err !== 4'd0 || b_first !== 4'd0) begin
      failures++;
      $display("FAIL reset_b got busy=%b done=%b chk=%0d want all 0", b_busy, b_done, b_chk);
    end
    Reset = 1'b0;
  endtask

  task automatic test_clean_run();
    start_run(1'b0);
    cyc(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    for (int i = 0; i < 40; i++)
      cyc((i >= 20 && i < 30), (i >= 5 && i < 15), (((i * 10 + 3) / 13) % 2 == 1),
          1'b0, 1'b1, (i == 39));
    checks++;
    if ({a_busy, a_done, a_pass, a_fail} !== 4'b0110 || a_chk !== 16'd40 || a_err !== 16'd0) begin
      failures++;
      $display("FAIL clean_run got busy=%b done=%b pass=%b fail=%b chk=%0d err=%0d want 0 1 1 0 chk=40 err=0",
               a_busy, a_done, a_pass, a_fail, a_chk, a_err);
    end
  endtask

  task automatic test_single_fault();
    start_run(1'b0);
    cyc(1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
    for (int i = 0; i < 20; i++) begin
      cyc(1'b0, 1'b0, ($urandom_range(0, 1) == 1), (i == 7), 1'b1, (i == 19));
      if (i == 6 || i == 7) begin
        checks++;
        if (a_fail !== (i == 7)) begin
          failures++;
          $display("FAIL fault_fail_timing i=%0d got=%b want=%b", i, a_fail, (i == 7));
        end
      end
    end
    checks++;
    if ({a_done, a_pass, a_fail} !== 3'b101 || a_err !== 16'd1 || a_first !== 16'd7 || a_chk !== 16'd20) begin
      failures++;
      $display("FAIL single_fault got done=%b pass=%b fail=%b err=%0d first=%0d chk=%0d want 1 0 1 err=1 first=7 chk=20",
               a_done, a_pass, a_fail, a_err, a_first, a_chk);
    end
  endtask

  task automatic test_priority();
    start_run(1'b0);
    cyc(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    cyc(1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0);
    prio_bug = 1'b1;
    cyc(1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0);
    prio_bug = 1'b0;
    checks++;
    if (a_exp_q !== 1'b0 || dut_q !== 1'b1) begin
      failures++;
      $display("FAIL priority_exp_q got exp_q=%b dut_q=%b want exp_q=0 dut_q=1", a_exp_q, dut_q);
    end
    // The mismatching compare also carries stop: it must still be counted.
    cyc(1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1);
    checks++;
    if ({a_done, a_pass, a_fail} !== 3'b101 || a_err !== 16'd1 || a_first !== 16'd2 || a_chk !== 16'd3) begin
      failures++;
      $display("FAIL priority_result got done=%b pass=%b fail=%b err=%0d first=%0d chk=%0d want 1 0 1 err=1 first=2 chk=3",
               a_done, a_pass, a_fail, a_err, a_first, a_chk);
    end
  endtask

  task automatic test_error_limit();
    start_run(1'b0);
    cyc(1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
    for (int i = 0; i < 8; i++) begin
      checks++;
      if (a_busy !== 1'b1) begin
        failures++;
        $display("FAIL limit_early_done i=%0d got busy=%b want 1", i, a_busy);
      end
      cyc(1'b0, 1'b0, (i % 2 == 0), 1'b1, 1'b1, 1'b0);
    end
    checks++;
    if ({a_busy, a_done, a_pass, a_fail} !== 4'b0101 || a_err !== 16'd8 || a_first !== 16'd0 || a_chk !== 16'd8) begin
      failures++;
      $display("FAIL error_limit got busy=%b done=%b pass=%b fail=%b err=%0d first=%0d chk=%0d want 0 1 0 1 err=8 first=0 chk=8",
               a_busy, a_done, a_pass, a_fail, a_err, a_first, a_chk);
    end
    stop = 1'b1;
    inject = 1'b1;
    tick();
    stop = 1'b0;
    inject = 1'b0;
    checks++;
    if (a_done !== 1'b1 || a_chk !== 16'd8 || a_err !== 16'd8 || b_done !== 1'b1) begin
      failures++;
      $display("FAIL limit_hold got a_done=%b a_chk=%0d a_err=%0d b_done=%b want 1 8 8 1",
               a_done, a_chk, a_err, b_done);
    end
  endtask

  task automatic test_back_to_back();
    start_run(1'b1);
    cyc(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    for (int i = 0; i < 5; i++) begin
      start = (i == 1);
      cyc(1'b0, 1'b0, (i > 2), (i % 2 == 0), 1'b1, 1'b0);
      start = 1'b0;
    end
    checks++;
    if (a_err !== 16'd3 || a_busy !== 1'b1) begin
      failures++;
      $display("FAIL midrun_err got err=%0d busy=%b want err=3 busy=1", a_err, a_busy);
    end
    Reset = 1'b1;
    start = 1'b1;
    stop  = 1'b1;
    tick();
    Reset = 1'b0;
    start = 1'b0;
    stop  = 1'b0;
    checks++;
    if ({a_busy, a_done, a_pass, a_fail, a_exp_q} !== 5'b0 || a_chk !== 16'd0 || a_err !== 16'd0 || a_first !== 16'd0 || b_chk !== 4'd0) begin
      failures++;
      $display("FAIL midrun_reset got busy=%b done=%b fail=%b exp_q=%b chk=%0d err=%0d first=%0d b_chk=%0d want all 0",
               a_busy, a_done, a_fail, a_exp_q, a_chk, a_err, a_first, b_chk);
    end
    tick();
    checks++;
    if (a_busy !== 1'b0 || a_done !== 1'b0) begin
      failures++;
      $display("FAIL reset_over_start got busy=%b done=%b want 0 0", a_busy, a_done);
    end
  endtask

  task automatic test_saturation();
    start_run(1'b0);
    cyc(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    for (int i = 0; i < 20; i++) begin
      cyc(1'b0, 1'b0, (i % 3 == 0), 1'b0, 1'b1, (i == 19));
      if (i == 17) begin
        checks++;
        if (b_chk !== 4'd15 || b_busy !== 1'b1) begin
          failures++;
          $display("FAIL sat_running got chk=%0d busy=%b want chk=15 busy=1", b_chk, b_busy);
        end
      end
    end
    checks++;
    if (b_chk !== 4'd15 || {b_done, b_pass, b_fail} !== 3'b110 || a_chk !== 16'd20) begin
      failures++;
      $display("FAIL sat_final got b_chk=%0d b_done=%b b_pass=%b b_fail=%b a_chk=%0d want 15 1 1 0 20",
               b_chk, b_done, b_pass, b_fail, a_chk);
    end
  endtask

  initial begin
    Reset     = 1'b1;
    start     = 1'b0;
    stop      = 1'b0;
    dut_reset = 1'b0;
    dut_set   = 1'b0;
    dut_d     = 1'b0;
    inject    = 1'b0;
    prio_bug  = 1'b0;
    exp_chk   = 0;
    exp_err   = 0;
    exp_first = 0;
    @(negedge CLK);
    test_reset();
    test_clean_run();
    test_single_fault();
    test_priority();
    test_error_limit();
    test_back_to_back();
    test_saturation();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
